// File: rtl/collision_search_scheduler.sv
// Multi-lane collision search scheduler: hands ascending counters to LANES hash lanes and
// reports the lowest counter whose returned digest has at least `target` leading zero bits.
module collision_search_scheduler #(
   parameter int LANES    = 4,
   parameter int DIGEST_W = 160,
   parameter int CNT_W    = 32,
   parameter int TGT_W    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [TGT_W-1:0]          target,
   input  logic [CNT_W-1:0]          base_counter,
   input  logic [CNT_W-1:0]          limit,
   output logic [LANES-1:0]          issue_valid,
   input  logic [LANES-1:0]          issue_ready,
   output logic [LANES*CNT_W-1:0]    issue_counter,
   input  logic [LANES-1:0]          dig_valid,
   input  logic [LANES*DIGEST_W-1:0] dig_data,
   input  logic [LANES*CNT_W-1:0]    dig_counter,
   output logic [CNT_W-1:0]          digests_computed,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [CNT_W-1:0]          result
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [TGT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] base_q, base_d, limit_q, limit_d, next_ctr_q, next_ctr_d;
   logic [CNT_W-1:0] issued_q, issued_d, outstanding_q, outstanding_d;
   logic [CNT_W-1:0] digests_q, digests_d, best_off_q, best_off_d, result_q, result_d;
   logic             found_q, found_d;

   logic [CNT_W-1:0] remaining, hs_cnt, ret_cnt, cand_off, cand_ctr, lane_ctr, lane_off;
   logic             ret_en, cand_hit, start_ok, limit_reached;

   // A target beyond the digest width can never be met.
   function automatic logic meets_target(input logic [DIGEST_W-1:0] dig,
                                         input logic [TGT_W-1:0] tgt);
      logic ok;
      ok = (int'(tgt) <= DIGEST_W);
      for (int b = 0; b < DIGEST_W; b++)
         if ((b < int'(tgt)) && dig[DIGEST_W-1-b]) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cand_hit || abort || limit_reached) state_d = S_DRAIN;
         S_DRAIN: if (outstanding_d == '0) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshaking lanes take consecutive counters in lane order, so each lane's counter
   // depends on how many lower lanes accept in the same cycle.
   always_comb begin
      busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
      done          = (state_q == S_DONE);
      remaining     = limit_q - issued_q;
      hs_cnt        = '0;
      issue_valid   = '0;
      issue_counter = '0;
      for (int i = 0; i < LANES; i++) begin
         issue_counter[i*CNT_W +: CNT_W] = next_ctr_q + hs_cnt;
         issue_valid[i] = (state_q == S_RUN) && ((limit_q == '0) || (CNT_W'(i) < remaining));
         if (issue_valid[i] && issue_ready[i]) hs_cnt = hs_cnt + CNT_W'(1);
      end
   end

   // Hits are ranked by distance from the base so the search order survives counter wrap.
   always_comb begin
      ret_en   = busy;
      ret_cnt  = ret_en ? popcount(dig_valid) : '0;
      cand_hit = 1'b0;
      cand_off = '0;
      cand_ctr = '0;
      lane_ctr = '0;
      lane_off = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_ctr = dig_counter[i*CNT_W +: CNT_W];
         lane_off = lane_ctr - base_q;
         if (ret_en && dig_valid[i] && meets_target(dig_data[i*DIGEST_W +: DIGEST_W], target_q)
             && (!cand_hit || (lane_off < cand_off))) begin
            cand_hit = 1'b1;
            cand_off = lane_off;
            cand_ctr = lane_ctr;
         end
      end
   end

   always_comb begin
      start_ok      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      limit_reached = (limit_q != '0) && ((issued_q + hs_cnt) >= limit_q);
      target_d      = target_q;
      base_d        = base_q;
      limit_d       = limit_q;
      next_ctr_d    = next_ctr_q;
      issued_d      = issued_q;
      outstanding_d = outstanding_q;
      digests_d     = digests_q;
      found_d       = found_q;
      best_off_d    = best_off_q;
      result_d      = result_q;
      if (start_ok) begin
         target_d      = target;
         base_d        = base_counter;
         limit_d       = limit;
         next_ctr_d    = base_counter;
         issued_d      = '0;
         outstanding_d = '0;
         digests_d     = '0;
         found_d       = 1'b0;
         best_off_d    = '0;
         result_d      = '0;
      end else if (ret_en) begin
         next_ctr_d    = next_ctr_q + hs_cnt;
         issued_d      = issued_q + hs_cnt;
         outstanding_d = outstanding_q + hs_cnt - ret_cnt;
         digests_d     = digests_q + ret_cnt;
         if (cand_hit && (!found_q || (cand_off < best_off_q))) begin
            found_d    = 1'b1;
            best_off_d = cand_off;
            result_d   = cand_ctr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         target_q      <= '0;
         base_q        <= '0;
         limit_q       <= '0;
         next_ctr_q    <= '0;
         issued_q      <= '0;
         outstanding_q <= '0;
         digests_q     <= '0;
         found_q       <= 1'b0;
         best_off_q    <= '0;
         result_q      <= '0;
      end else begin
         target_q      <= target_d;
         base_q        <= base_d;
         limit_q       <= limit_d;
         next_ctr_q    <= next_ctr_d;
         issued_q      <= issued_d;
         outstanding_q <= outstanding_d;
         digests_q     <= digests_d;
         found_q       <= found_d;
         best_off_q    <= best_off_d;
         result_q      <= result_d;
      end
   end

   assign digests_computed = digests_q;
   assign found            = found_q;
   assign result           = result_q;

   a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      ret_en |-> (ret_cnt <= outstanding_q));
   a_no_stray_return: assert property (@(posedge clk) disable iff (!reset)
      (ret_en && (dig_valid != '0)) |-> (outstanding_q != '0));

endmodule

// File: tb/tb_collision_search_scheduler.sv
// Directed bench for collision_search_scheduler: a lane model returns digests after a
// per-lane latency, and a behavioural model checks the scheduler outputs every cycle.
module tb_collision_search_scheduler;
   localparam int LANES    = 4;
   localparam int DIGEST_W = 160;
   localparam int CNT_W    = 32;
   localparam int TGT_W    = 8;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
   logic [TGT_W-1:0]          target = '0;
   logic [CNT_W-1:0]          base_counter = '0, limit = '0;
   logic [LANES-1:0]          issue_valid, issue_ready = '0, dig_valid = '0;
   logic [LANES*CNT_W-1:0]    issue_counter, dig_counter = '0;
   logic [LANES*DIGEST_W-1:0] dig_data = '0;
   logic [CNT_W-1:0]          digests_computed, result;
   logic                      busy, done, found;

   always #5 clk = ~clk;

   collision_search_scheduler #(.LANES(LANES), .DIGEST_W(DIGEST_W), .CNT_W(CNT_W), .TGT_W(TGT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
      .base_counter(base_counter), .limit(limit), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_counter(issue_counter), .dig_valid(dig_valid),
      .dig_data(dig_data), .dig_counter(dig_counter), .digests_computed(digests_computed),
      .busy(busy), .done(done), .found(found), .result(result)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Lane model configuration
   int lat [LANES];
   int hit_z = 20, miss_z = 19;
   bit ready_toggle = 1'b0;
   logic [CNT_W-1:0] hit_list [$];

   typedef struct packed { int lane; logic [CNT_W-1:0] ctr; int due; } pend_t;
   pend_t pend [$];
   logic [CNT_W-1:0] hs_log [$];
   int tot_hs = 0;
   int cyc = 0;

   function automatic bit is_hit_ctr(input logic [CNT_W-1:0] c);
      foreach (hit_list[j]) if (hit_list[j] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DIGEST_W-1:0] make_digest(input logic [CNT_W-1:0] c);
      logic [DIGEST_W-1:0] d;
      int z;
      z = is_hit_ctr(c) ? hit_z : miss_z;
      d = '0;
      if (z < DIGEST_W) d[DIGEST_W-1-z] = 1'b1;
      return d;
   endfunction

   function automatic int lzc(input logic [DIGEST_W-1:0] d);
      for (int b = DIGEST_W-1; b >= 0; b--) if (d[b]) return DIGEST_W-1-b;
      return DIGEST_W;
   endfunction

   // Lane side: ready pattern and due digest returns for the cycle just begun.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      for (int i = 0; i < LANES; i++)
         issue_ready[i] = ready_toggle ? (((cyc + i) % 2 == 0) || (i == 3 && cyc % 3 == 0)) : 1'b1;
      dig_valid   = '0;
      dig_data    = '0;
      dig_counter = '0;
      foreach (pend[j]) begin
         if (pend[j].due == cyc) begin
            dig_valid[pend[j].lane] = 1'b1;
            dig_counter[pend[j].lane*CNT_W +: CNT_W] = pend[j].ctr;
            dig_data[pend[j].lane*DIGEST_W +: DIGEST_W] = make_digest(pend[j].ctr);
         end
      end
   end

   // Behavioural model of the run: phase, counters, best hit
   int               m_phase = M_IDLE;
   logic [CNT_W-1:0] m_base = '0, m_limit = '0, m_next = '0, m_issued = '0, m_dig = '0, m_best_off = '0;
   logic [TGT_W-1:0] m_tgt = '0;
   bit               m_found = 1'b0;

   always @(negedge clk) begin
      logic [LANES-1:0] exp_v;
      logic [CNT_W-1:0] exp_ctr, exp_res, off;
      longint           rem;
      int               k, nret;
      bit               hit_now;
      pend_t            e;
      pend_t            keep [$];
      if (cyc > 0) begin
         chk("busy", busy, (m_phase == M_RUN) || (m_phase == M_DRAIN));
         chk("done", done, m_phase == M_DONE);
         chk("digests_computed", digests_computed, m_dig);
         if (m_phase == M_DONE) begin
            chk("found", found, m_found);
            exp_res = m_base + m_best_off;
            if (m_found) chk("result", result, exp_res);
         end else if (m_phase == M_IDLE) begin
            chk("found_idle", found, 1'b0);
            chk("result_idle", result, '0);
         end
         exp_v = '0;
         rem = longint'(m_limit) - longint'(m_issued);
         for (int i = 0; i < LANES; i++)
            if (m_phase == M_RUN && (m_limit == '0 || i < rem)) exp_v[i] = 1'b1;
         chk("issue_valid", issue_valid, exp_v);
         k = 0;
         for (int i = 0; i < LANES; i++) begin
            if (exp_v[i] && issue_ready[i]) begin
               exp_ctr = m_next + CNT_W'(k);
               chk("issue_counter", issue_counter[i*CNT_W +: CNT_W], exp_ctr);
               if (reset) begin
                  e.lane = i;
                  e.ctr  = issue_counter[i*CNT_W +: CNT_W];
                  e.due  = cyc + lat[i];
                  pend.push_back(e);
                  hs_log.push_back(e.ctr);
                  tot_hs++;
               end
               k++;
            end
         end
         if (!reset) begin
            m_phase = M_IDLE; m_base = '0; m_limit = '0; m_next = '0; m_issued = '0;
            m_dig = '0; m_best_off = '0; m_tgt = '0; m_found = 1'b0;
            pend.delete();
         end else begin
            nret = 0;
            hit_now = 1'b0;
            keep.delete();
            foreach (pend[j]) begin
               if (pend[j].due == cyc) begin
                  nret++;
                  if ((m_phase == M_RUN || m_phase == M_DRAIN) &&
                      lzc(make_digest(pend[j].ctr)) >= int'(m_tgt)) begin
                     hit_now = 1'b1;
                     off = pend[j].ctr - m_base;
                     if (!m_found || off < m_best_off) begin
                        m_found = 1'b1;
                        m_best_off = off;
                     end
                  end
               end else begin
                  keep.push_back(pend[j]);
               end
            end
            pend = keep;
            if (m_phase == M_RUN || m_phase == M_DRAIN) begin
               m_dig    = m_dig + CNT_W'(nret);
               m_next   = m_next + CNT_W'(k);
               m_issued = m_issued + CNT_W'(k);
            end
            if (start && (m_phase == M_IDLE || m_phase == M_DONE)) begin
               m_phase = M_RUN; m_base = base_counter; m_limit = limit; m_tgt = target;
               m_next = base_counter; m_issued = '0; m_dig = '0; m_found = 1'b0; m_best_off = '0;
            end else if (m_phase == M_RUN) begin
               if (hit_now || abort || (m_limit != '0 && m_issued >= m_limit)) m_phase = M_DRAIN;
            end else if (m_phase == M_DRAIN) begin
               if (pend.size() == 0) m_phase = M_DONE;
            end
         end
      end
   end

   task automatic set_lat(input int a, input int b, input int c, input int d);
      lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
   endtask

   task automatic start_run(input logic [TGT_W-1:0] t, input logic [CNT_W-1:0] b,
                            input logic [CNT_W-1:0] l);
      tot_hs = 0;
      hs_log.delete();
      @(posedge clk); #1;
      target = t; base_counter = b; limit = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      int n;
      n = 0;
      while (!done && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, done, 1'b1);
   endtask

   initial begin
      int cnt;
      logic [CNT_W-1:0] want;
      set_lat(3, 3, 3, 3);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Every digest hits with target 0
      hit_list.delete(); hit_z = 0; miss_z = 0;
      start_run(8'd0, 32'h10, 32'd0);
      wait_done("t1", 200);
      chk("t1_found", found, 1'b1);
      chk("t1_result", result, 32'h10);
      chk("t1_digests", digests_computed, 32'd16);
      chk("t1_digests_eq_issued", digests_computed, 32'(tot_hs));
      pulse_abort();
      @(negedge clk);
      chk("t1_abort_in_done", done, 1'b1);

      // Single hit at exactly 20 leading zeros; misses have 19
      hit_list.delete(); hit_list.push_back(32'h25); hit_z = 20; miss_z = 19;
      start_run(8'd20, 32'h0, 32'd0);
      wait_done("t2", 300);
      chk("t2_found", found, 1'b1);
      chk("t2_result", result, 32'h25);
      chk("t2_digests", digests_computed, 32'd52);

      // Out-of-order returns: 0x31 comes back before 0x2E
      set_lat(3, 2, 8, 3);
      hit_list.delete(); hit_list.push_back(32'h2E); hit_list.push_back(32'h31);
      start_run(8'd20, 32'h2C, 32'd0);
      wait_done("t3", 300);
      chk("t3_found", found, 1'b1);
      chk("t3_result", result, 32'h2E);
      chk("t3_digests", digests_computed, 32'd16);

      // Wrap: offset from base decides, not raw counter value
      set_lat(3, 3, 3, 3);
      hit_list.delete(); hit_list.push_back(32'h1); hit_list.push_back(32'hFFFF_FFFF);
      start_run(8'd20, 32'hFFFF_FFFE, 32'd0);
      wait_done("t4", 300);
      chk("t4_found", found, 1'b1);
      chk("t4_result", result, 32'hFFFF_FFFF);

      // Limit 10, toggling ready, target above digest width never hits
      hit_list.delete(); miss_z = DIGEST_W; ready_toggle = 1'b1;
      start_run(8'd200, 32'h100, 32'd10);
      wait_done("t5", 400);
      chk("t5_found", found, 1'b0);
      chk("t5_digests", digests_computed, 32'd10);
      chk("t5_issue_total", 32'(hs_log.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         cnt = 0;
         want = 32'h100 + 32'(i);
         foreach (hs_log[j]) if (hs_log[j] == want) cnt++;
         chk($sformatf("t5_issued_once_%0d", i), 32'(cnt), 32'd1);
      end
      ready_toggle = 1'b0;

      // Abort two cycles into a run
      miss_z = 19;
      start_run(8'd20, 32'h0, 32'd0);
      pulse_abort();
      wait_done("t6a", 300);
      chk("t6a_found", found, 1'b0);
      chk("t6a_digests", digests_computed, 32'd8);

      // Second run aborted, then reset while draining
      set_lat(6, 6, 6, 6);
      start_run(8'd20, 32'h0, 32'd0);
      pulse_abort();
      chk("t6b_draining", busy, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("t6b_busy", busy, 1'b0);
      chk("t6b_done", done, 1'b0);
      chk("t6b_found", found, 1'b0);
      chk("t6b_result", result, 32'd0);
      chk("t6b_digests", digests_computed, 32'd0);
      chk("t6b_issue_valid", issue_valid, 4'b0000);

      // Normal run after reset
      set_lat(3, 3, 3, 3);
      miss_z = 0;
      start_run(8'd0, 32'h40, 32'd0);
      wait_done("t6c", 200);
      chk("t6c_found", found, 1'b1);
      chk("t6c_result", result, 32'h40);
      chk("t6c_digests", digests_computed, 32'd16);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
